alu_stage: RTL and testbench
============================

ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width for rs1, rs2, imm and rd.
REQ-002 SHALL have ports, one clock domain; reset is asynchronous and active-high:
  clk        input   1     single clock, rising edge
  rst        input   1     asynchronous active-high reset
  START      input   1     one-cycle pulse, new instruction operands valid
  OP         input   4     operation code (alu_pkg::alu_op_t)
  rs1        input   XLEN  source 1 data from register file
  rs2        input   XLEN  source 2 data from register file
  imm        input   XLEN  immediate operand
  USE_IMM    input   1     1 = second operand is imm, 0 = rs2
  rdAddr_in  input   5     destination register address
  DONE_RF    input   1     register file has written rd
  rd         output  XLEN  result to register file
  rdAddr     output  5     latched destination address
  DONE_ALU   output  1     rd/rdAddr valid, write request to register file
  BUSY       output  1     instruction in flight
  ILLEGAL    output  1     undefined or disabled opcode completed

Function
REQ-003 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; BUSY=1 in EXEC and DONE.
REQ-004 SHALL sample START only in IDLE; in that cycle latch OP, rs1, operand B (imm if USE_IMM else rs2) and rdAddr_in; enter EXEC next cycle.
REQ-005 SHALL ignore START in EXEC and DONE; no queuing.
REQ-006 ADD, SUB, AND, OR, XOR, SLT (signed), SLTU (unsigned) SHALL spend exactly 1 cycle in EXEC; START at cycle T gives DONE_ALU=1 at T+2.
REQ-007 ADD/SUB SHALL wrap modulo 2^XLEN; no overflow flag; SLT/SLTU return 1 or 0 zero-extended.
REQ-008 SLL, SRL, SRA SHALL shift one bit per EXEC cycle using shamt = operand B[4:0]; EXEC lasts max(shamt,1) cycles; shamt=0 returns rs1 unchanged.
REQ-009 SRA SHALL replicate bit XLEN-1; SRL SHALL fill zeros.
REQ-010 In DONE, rd, rdAddr, ILLEGAL SHALL be stable and DONE_ALU=1 until DONE_RF=1 is sampled; FSM returns to IDLE next cycle, DONE_ALU=0.
REQ-011 DONE_RF outside DONE SHALL be ignored.
REQ-012 START and DONE_RF in the same DONE cycle: START ignored (FSM not yet IDLE).
REQ-013 Undefined OP SHALL spend 1 EXEC cycle, give rd=0, ILLEGAL=1 in DONE.
REQ-014 Writes with rdAddr=0 SHALL still complete the handshake; zeroing is the register file's job.

Reset
REQ-015 rst=1 SHALL force IDLE immediately, any cycle including mid-shift or mid-multiply; rd=0, rdAddr=0, DONE_ALU=0, BUSY=0, ILLEGAL=0; partial results discarded.
REQ-016 First START after rst deasserts SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-017 Macro ALU_STAGE_MUL_EN defined: OP MUL SHALL run shift-add multiply, 1 bit per cycle, exactly 32 EXEC cycles, rd = low XLEN bits of product (DONE_ALU at T+33).
REQ-018 ALU_STAGE_MUL_EN undefined: MUL SHALL behave as undefined OP (REQ-013); no multiplier logic synthesized.

Structure
REQ-019 Package alu_pkg SHALL hold alu_op_t (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, MUL=10), state enum alu_state_t, XLEN_DEF=32.
REQ-020 Iterative shift/multiply datapath SHALL be sub-module alu_iter_unit (load, step, count, done); top holds FSM and single-cycle ops.

Verification
REQ-021 Reset then START, ADD, rs1=5, rs2=7 -> DONE_ALU at T+2, rd=12; DONE_RF next cycle -> DONE_ALU=0, BUSY=0.
REQ-022 SUB rs1=0, rs2=1 -> rd=0xFFFFFFFF; SLT 0xFFFFFFFF vs 1 -> rd=1; SLTU same -> rd=0.
REQ-023 SRA rs1=0x80000000, USE_IMM=1, imm=4 -> DONE_ALU at T+5, rd=0xF8000000; SLL shamt=0 -> rd=rs1 at T+2.
REQ-024 Hold DONE_RF=0 for 10 cycles in DONE with START pulses -> rd stable, START ignored; then DONE_RF=1 -> IDLE.
REQ-025 rst asserted on 3rd EXEC cycle of SRL shamt=20 -> outputs zero same cycle; next ADD 1+1 -> rd=2.
REQ-026 MUL 0x10000 x 0x10001: with ALU_STAGE_MUL_EN rd=0x00010000 at T+33; without it rd=0, ILLEGAL=1 at T+2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state enums and shared constants for alu_stage.
// Optional feature macro: ALU_STAGE_MUL_EN (iterative shift-add MUL).
package alu_pkg;

  localparam int XLEN_DEF = 32;

`ifdef ALU_STAGE_MUL_EN
  // Fixed multiply length, one multiplier bit per cycle
  localparam int MUL_CYCLES = 32;
`endif

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9,
    MUL  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  // Ops whose result comes from the multi-cycle iterative unit
  function automatic logic is_iter_op(alu_op_t op);
    logic r;
    r = (op == SLL) || (op == SRL) || (op == SRA);
`ifdef ALU_STAGE_MUL_EN
    r = r || (op == MUL);
`endif
    return r;
  endfunction

endpackage

// File: rtl/alu_stage_if.sv
// alu_stage_if: instruction issue / register-file writeback handshake.
// master = issuing side (decoder / register file), slave = alu_stage.
interface alu_stage_if import alu_pkg::*; #(parameter int XLEN = XLEN_DEF);

  logic            START;
  alu_op_t         OP;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            USE_IMM;
  logic [4:0]      rdAddr_in;
  logic            DONE_RF;
  logic [XLEN-1:0] rd;
  logic [4:0]      rdAddr;
  logic            DONE_ALU;
  logic            BUSY;
  logic            ILLEGAL;

  modport master (
    output START, OP, rs1, rs2, imm, USE_IMM, rdAddr_in, DONE_RF,
    input  rd, rdAddr, DONE_ALU, BUSY, ILLEGAL
  );

  modport slave (
    input  START, OP, rs1, rs2, imm, USE_IMM, rdAddr_in, DONE_RF,
    output rd, rdAddr, DONE_ALU, BUSY, ILLEGAL
  );

endinterface

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle shifter (SLL/SRL/SRA) and, when
// ALU_STAGE_MUL_EN is defined, a shift-add multiplier.
// load captures operands; each step advances one bit; done flags that the
// current step is the last one, and res_nxt is the value after that step.
module alu_iter_unit import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res_nxt
);

  alu_op_t         op_q;
  logic [XLEN-1:0] acc;
  logic [5:0]      cnt;

`ifdef ALU_STAGE_MUL_EN
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
`else
  logic unused_b;
  assign unused_b = ^b[XLEN-1:5];
`endif

  // shamt=0 leaves cnt at 0: one EXEC cycle, acc passes through unchanged
  assign done = (cnt <= 6'd1);

  // Value of acc after the current step
  always_comb begin
    res_nxt = acc;
    if (cnt != 6'd0) begin
      case (op_q)
        SLL:     res_nxt = {acc[XLEN-2:0], 1'b0};
        SRL:     res_nxt = {1'b0, acc[XLEN-1:1]};
        SRA:     res_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
`ifdef ALU_STAGE_MUL_EN
        MUL:     res_nxt = mplier[0] ? (acc + mcand) : acc;
`endif
        default: res_nxt = acc;
      endcase
    end
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= ADD;
      acc    <= '0;
      cnt    <= '0;
`ifdef ALU_STAGE_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else if (load) begin
      op_q <= op;
      acc  <= a;
      cnt  <= {1'b0, b[4:0]};
`ifdef ALU_STAGE_MUL_EN
      mcand  <= a;
      mplier <= b;
      if (op == MUL) begin
        acc <= '0;
        cnt <= 6'(MUL_CYCLES);
      end
`endif
    end else if (step) begin
      acc <= res_nxt;
      if (cnt != 6'd0) cnt <= cnt - 6'd1;
`ifdef ALU_STAGE_MUL_EN
      mcand  <= {mcand[XLEN-2:0], 1'b0};
      mplier <= {1'b0, mplier[XLEN-1:1]};
`endif
    end
  end

endmodule

// File: rtl/alu_stage.sv
// alu_stage: single-issue ALU with IDLE -> EXEC -> DONE handshake FSM.
// Logic ops, add/sub and compares finish in one EXEC cycle; shifts (and MUL
// when ALU_STAGE_MUL_EN is defined) iterate in alu_iter_unit. Without
// ALU_STAGE_MUL_EN, MUL is reported as an illegal opcode.
module alu_stage import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input logic       clk,
  input logic       rst,
  alu_stage_if.slave bus
);

  alu_state_t      state;
  alu_op_t         op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] rd_q;
  logic [4:0]      rd_addr_q;
  logic            done_q, busy_q, ill_q;

  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            iter_load, iter_step, iter_done;
  logic [XLEN-1:0] iter_res;

  assign opb       = bus.USE_IMM ? bus.imm : bus.rs2;
  assign iter_load = (state == S_IDLE) && bus.START;
  assign iter_step = (state == S_EXEC) && is_iter_op(op_q);

  assign bus.rd       = rd_q;
  assign bus.rdAddr   = rd_addr_q;
  assign bus.DONE_ALU = done_q;
  assign bus.BUSY     = busy_q;
  assign bus.ILLEGAL  = ill_q;

  alu_iter_unit #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (iter_load),
    .step    (iter_step),
    .op      (bus.OP),
    .a       (bus.rs1),
    .b       (opb),
    .done    (iter_done),
    .res_nxt (iter_res)
  );

  // Single-cycle results; anything not decoded here or iterative is illegal
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      ADD:  alu_res = a_q + b_q;
      SUB:  alu_res = a_q - b_q;
      AND:  alu_res = a_q & b_q;
      OR:   alu_res = a_q | b_q;
      XOR:  alu_res = a_q ^ b_q;
      SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      SLL, SRL, SRA: alu_res = '0;
`ifdef ALU_STAGE_MUL_EN
      MUL:  alu_res = '0;
`endif
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // Handshake FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            op_q      <= bus.OP;
            a_q       <= bus.rs1;
            b_q       <= opb;
            rd_addr_q <= bus.rdAddr_in;
            busy_q    <= 1'b1;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!is_iter_op(op_q)) begin
            rd_q   <= alu_res;
            ill_q  <= alu_ill;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (iter_done) begin
            rd_q   <= iter_res;
            ill_q  <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          // START in this cycle is dropped: the FSM is not IDLE yet
          if (bus.DONE_RF) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ill_q  <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed + random stimulus against a behavioural model.
module tb_alu_stage;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_stage_if #(.XLEN(XLEN)) bus ();

  alu_stage #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result, illegal flag and START-to-DONE_ALU latency in cycles
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    logic signed [31:0] sa;
    sh  = int'(b % 32);
    sa  = a;
    r   = 32'd0;
    ill = 1'b0;
    lat = 2;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: begin r = a << sh;  lat = (sh == 0 ? 1 : sh) + 1; end
      4'd8: begin r = a >> sh;  lat = (sh == 0 ? 1 : sh) + 1; end
      4'd9: begin r = sa >>> sh; lat = (sh == 0 ? 1 : sh) + 1; end
`ifdef ALU_STAGE_MUL_EN
      4'd10: begin r = a * b; lat = 33; end
`endif
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Issue one instruction (caller is at a negedge), check latency and
  // result, hold in DONE for ack_wait cycles, then acknowledge.
  // poke: hammer START during the hold and together with DONE_RF.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] r2, input logic [31:0] im, input logic ui,
                        input logic [4:0] ad, input int ack_wait, input bit poke);
    logic [31:0] b, er;
    logic        eil;
    int          lat;
    b = ui ? im : r2;
    model(op, a, b, er, eil, lat);
    bus.START = 1'b1; bus.OP = alu_op_t'(op); bus.rs1 = a; bus.rs2 = r2;
    bus.imm = im; bus.USE_IMM = ui; bus.rdAddr_in = ad;
    @(posedge clk); #1 bus.START = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check({tag, "_done_lat"}, 32'(bus.DONE_ALU), 32'(c == lat));
      if (c == 1) check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    end
    check({tag, "_rd"}, bus.rd, er);
    check({tag, "_rdaddr"}, 32'(bus.rdAddr), 32'(ad));
    check({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'(eil));
    for (int k = 0; k < ack_wait; k++) begin
      if (poke) begin
        bus.START = 1'b1; bus.OP = SUB; bus.rs1 = $urandom; bus.rdAddr_in = 5'd31;
      end
      @(negedge clk);
      bus.START = 1'b0;
      check({tag, "_hold_done"}, 32'(bus.DONE_ALU), 32'd1);
      check({tag, "_hold_rd"}, bus.rd, er);
      check({tag, "_hold_rdaddr"}, 32'(bus.rdAddr), 32'(ad));
    end
    bus.DONE_RF = 1'b1;
    if (poke) bus.START = 1'b1;
    @(posedge clk); #1 bus.DONE_RF = 1'b0; bus.START = 1'b0;
    @(negedge clk);
    check({tag, "_ack_done"}, 32'(bus.DONE_ALU), 32'd0);
    check({tag, "_ack_busy"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_ack_ill"}, 32'(bus.ILLEGAL), 32'd0);
    if (poke) begin
      @(negedge clk);
      check({tag, "_start_ignored"}, 32'(bus.BUSY), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] rop;
    rst = 1'b1;
    bus.START = 1'b0; bus.OP = ADD; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    bus.USE_IMM = 1'b0; bus.rdAddr_in = '0; bus.DONE_RF = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_rd", bus.rd, 32'd0);
    check("rst_rdaddr", 32'(bus.rdAddr), 32'd0);
    check("rst_done", 32'(bus.DONE_ALU), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_ill", 32'(bus.ILLEGAL), 32'd0);

    // START on the first edge after reset release
    rst = 1'b0;
    run_op("add_5_7", 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 0, 1'b0);
    check("add_5_7_const", bus.rd, 32'd12);
    run_op("sub_wrap", 4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 5'd4, 1, 1'b0);
    run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 0, 1'b0);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 0, 1'b0);
    run_op("sra_imm4", 4'd9, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd7, 0, 1'b0);
    check("sra_imm4_const", bus.rd, 32'hF800_0000);
    run_op("sll_sh0", 4'd7, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1, 5'd8, 0, 1'b0);
    run_op("srl_sh31", 4'd8, 32'h8000_0001, 32'd31, 32'd0, 1'b0, 5'd9, 0, 1'b0);
    run_op("mul", 4'd10, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 5'd10, 0, 1'b0);
    run_op("undef_op", 4'd15, 32'h1234_5678, 32'd9, 32'd0, 1'b0, 5'd11, 0, 1'b0);
    run_op("rd_x0", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 5'd0, 0, 1'b0);
    run_op("hold_poke", 4'd3, 32'h00FF_0000, 32'h0000_00FF, 32'd0, 1'b0, 5'd12, 10, 1'b1);

    // DONE_RF while idle does nothing
    bus.DONE_RF = 1'b1;
    @(posedge clk); #1 bus.DONE_RF = 1'b0;
    @(negedge clk);
    check("idle_donerf_busy", 32'(bus.BUSY), 32'd0);
    check("idle_donerf_done", 32'(bus.DONE_ALU), 32'd0);

    // Reset on the 3rd EXEC cycle of a 20-bit SRL
    bus.START = 1'b1; bus.OP = SRL; bus.rs1 = 32'hFFFF_0000; bus.imm = 32'd20;
    bus.USE_IMM = 1'b1; bus.rdAddr_in = 5'd13;
    @(posedge clk); #1 bus.START = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rd", bus.rd, 32'd0);
    check("midrst_rdaddr", 32'(bus.rdAddr), 32'd0);
    check("midrst_done", 32'(bus.DONE_ALU), 32'd0);
    check("midrst_busy", 32'(bus.BUSY), 32'd0);
    check("midrst_ill", 32'(bus.ILLEGAL), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd14, 0, 1'b0);
    check("post_rst_add_const", bus.rd, 32'd2);

    // Random instructions
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 11));
      if (($urandom % 8) == 0) rop = 4'd15;
      run_op("rand", rop, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom),
             int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
